sort_rd_arbiter: RTL and testbench

- Shares the single host-memory AXI read master between KERNEL_NUM sort kernels inside the sort framework.
- Round-robin arbitrates the kernels' read-address requests onto m_axi_snap_ar*, tagging each request with arid = kernel index.
- Routes R beats back to the requesting kernel by rid.
- Enforces a per-kernel outstanding-burst limit.

---
 rtl/sort_rd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sort_rd_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_rd_arbiter.sv
// Round-robin AXI read-address arbiter for the sort kernels, with per-kernel
// outstanding-burst limits and rid-based routing of R beats back to kernels.
module sort_rd_arbiter #(
    parameter int unsigned KERNEL_NUM = 8,
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_OUTS   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [KERNEL_NUM-1:0]            k_arvalid,
    output logic [KERNEL_NUM-1:0]            k_arready,
    input  logic [KERNEL_NUM*ADDR_WIDTH-1:0] k_araddr,
    input  logic [KERNEL_NUM*8-1:0]          k_arlen,
    output logic [KERNEL_NUM-1:0]            k_rvalid,
    input  logic [KERNEL_NUM-1:0]            k_rready,
    output logic [DATA_WIDTH-1:0]            k_rdata,
    output logic                             k_rlast,
    output logic [1:0]                       k_rresp,
    output logic [ID_WIDTH-1:0]              m_axi_snap_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_snap_araddr,
    output logic [7:0]                       m_axi_snap_arlen,
    output logic [2:0]                       m_axi_snap_arsize,
    output logic [1:0]                       m_axi_snap_arburst,
    output logic                             m_axi_snap_arvalid,
    input  logic                             m_axi_snap_arready,
    input  logic [ID_WIDTH-1:0]              m_axi_snap_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_snap_rdata,
    input  logic [1:0]                       m_axi_snap_rresp,
    input  logic                             m_axi_snap_rlast,
    input  logic                             m_axi_snap_rvalid,
    output logic                             m_axi_snap_rready,
    output logic                             o_rid_err
);

    localparam int unsigned IDX_W = $clog2(KERNEL_NUM);
    localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);

    typedef enum logic {AR_IDLE, AR_HOLD} ar_state_e;

    ar_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      outs_q [KERNEL_NUM];
    logic [CNT_W-1:0]      outs_d [KERNEL_NUM];
    logic                  rid_err_q, rid_err_d;

    logic [KERNEL_NUM-1:0] eligible;
    logic [KERNEL_NUM-1:0] grant_oh;
    logic [KERNEL_NUM-1:0] r_done;
    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand;
    logic                  capture;
    logic                  rid_in_range;
    logic [IDX_W-1:0]      rid_idx;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
            eligible[i] = k_arvalid[i] && (32'(outs_q[i]) < MAX_OUTS);
        end
    end

    // Search starts one past the last grant and wraps, ending on last_grant itself.
    always_comb begin
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 1; off <= KERNEL_NUM; off++) begin
            cand = IDX_W'((32'(last_grant_q) + off) % KERNEL_NUM);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign capture = (state_q == AR_IDLE) || m_axi_snap_arready;

    always_comb begin
        grant_oh = '0;
        if (capture && grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign k_arready = grant_oh;

    always_comb begin
        state_d      = state_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        last_grant_d = last_grant_q;
        if (capture) begin
            if (grant_vld) begin
                state_d      = AR_HOLD;
                arid_d       = ID_WIDTH'(grant_idx);
                araddr_d     = k_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                arlen_d      = k_arlen[grant_idx*8 +: 8];
                last_grant_d = grant_idx;
            end else begin
                state_d = AR_IDLE;
            end
        end
    end

    assign rid_in_range = 32'(m_axi_snap_rid) < KERNEL_NUM;
    assign rid_idx      = IDX_W'(m_axi_snap_rid);

    // Beats with an unknown rid are drained so the shared R channel never stalls.
    assign m_axi_snap_rready = rid_in_range ? k_rready[rid_idx] : 1'b1;

    always_comb begin
        k_rvalid = '0;
        r_done   = '0;
        if (m_axi_snap_rvalid && rid_in_range) begin
            k_rvalid[rid_idx] = 1'b1;
            r_done[rid_idx]   = m_axi_snap_rready && m_axi_snap_rlast;
        end
    end

    assign rid_err_d = rid_err_q || (m_axi_snap_rvalid && !rid_in_range);

    always_comb begin
        for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
            outs_d[i] = outs_q[i];
            if (grant_oh[i] && !r_done[i]) begin
                outs_d[i] = outs_q[i] + CNT_W'(1);
            end else if (r_done[i] && !grant_oh[i] && outs_q[i] != '0) begin
                outs_d[i] = outs_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= AR_IDLE;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            last_grant_q <= IDX_W'(KERNEL_NUM - 1);
            rid_err_q    <= 1'b0;
            for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
                outs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            last_grant_q <= last_grant_d;
            rid_err_q    <= rid_err_d;
            for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
                outs_q[i] <= outs_d[i];
            end
        end
    end

    assign m_axi_snap_arvalid = (state_q == AR_HOLD);
    assign m_axi_snap_arid    = arid_q;
    assign m_axi_snap_araddr  = araddr_q;
    assign m_axi_snap_arlen   = arlen_q;
    assign m_axi_snap_arsize  = 3'b110;
    assign m_axi_snap_arburst = 2'b01;

    assign k_rdata  = m_axi_snap_rdata;
    assign k_rlast  = m_axi_snap_rlast;
    assign k_rresp  = m_axi_snap_rresp;
    assign o_rid_err = rid_err_q;

endmodule

// File: tb/tb_sort_rd_arbiter.sv
// Scoreboard bench for sort_rd_arbiter: randomized kernel/memory traffic against
// a queue-based reference model, with directed phases for the notable corners.
module tb_sort_rd_arbiter;

    localparam int K   = 8;
    localparam int IDW = 5;
    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int MO  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [K-1:0]       k_arvalid, k_arready, k_rvalid, k_rready;
    logic [K*AW-1:0]    k_araddr;
    logic [K*8-1:0]     k_arlen;
    logic [DW-1:0]      k_rdata;
    logic               k_rlast;
    logic [1:0]         k_rresp;
    logic [IDW-1:0]     m_axi_snap_arid;
    logic [AW-1:0]      m_axi_snap_araddr;
    logic [7:0]         m_axi_snap_arlen;
    logic [2:0]         m_axi_snap_arsize;
    logic [1:0]         m_axi_snap_arburst;
    logic               m_axi_snap_arvalid, m_axi_snap_arready;
    logic [IDW-1:0]     m_axi_snap_rid;
    logic [DW-1:0]      m_axi_snap_rdata;
    logic [1:0]         m_axi_snap_rresp;
    logic               m_axi_snap_rlast, m_axi_snap_rvalid, m_axi_snap_rready;
    logic               o_rid_err;

    sort_rd_arbiter #(
        .KERNEL_NUM(K), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTS(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .k_arvalid(k_arvalid), .k_arready(k_arready), .k_araddr(k_araddr), .k_arlen(k_arlen),
        .k_rvalid(k_rvalid), .k_rready(k_rready), .k_rdata(k_rdata), .k_rlast(k_rlast),
        .k_rresp(k_rresp),
        .m_axi_snap_arid(m_axi_snap_arid), .m_axi_snap_araddr(m_axi_snap_araddr),
        .m_axi_snap_arlen(m_axi_snap_arlen), .m_axi_snap_arsize(m_axi_snap_arsize),
        .m_axi_snap_arburst(m_axi_snap_arburst), .m_axi_snap_arvalid(m_axi_snap_arvalid),
        .m_axi_snap_arready(m_axi_snap_arready), .m_axi_snap_rid(m_axi_snap_rid),
        .m_axi_snap_rdata(m_axi_snap_rdata), .m_axi_snap_rresp(m_axi_snap_rresp),
        .m_axi_snap_rlast(m_axi_snap_rlast), .m_axi_snap_rvalid(m_axi_snap_rvalid),
        .m_axi_snap_rready(m_axi_snap_rready), .o_rid_err(o_rid_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int id; } grant_t;
    typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [K-1:0] kv; logic rdy; logic [DW-1:0] data; logic last; logic [1:0] resp; } r_t;
    typedef struct { int id; int len; } ret_t;

    grant_t grant_q[$];
    ar_t    ar_q[$];
    r_t     r_q[$];
    ret_t   ret_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    bit             pend_v [K];
    logic [AW-1:0]  pend_addr [K];
    logic [7:0]     pend_len [K];
    int             outs_m [K];
    int             last_m;
    bit             hold_m;
    int             hold_id, hold_len;
    bit             err_m;
    bit             r_active;
    int             r_id, r_left;
    logic [DW-1:0]  r_data;
    logic [1:0]     r_resp;

    // stimulus knobs
    logic [K-1:0] req_mask;
    int           req_pct, ar_mode, rr_pct, stray_pct;
    bit           r_en;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int off = 1; off <= K; off++) begin
            int c = (last_m + off) % K;
            if (pend_v[c] && outs_m[c] < MO) return c;
        end
        return -1;
    endfunction

    task automatic new_beat();
        for (int w = 0; w < DW / 32; w++) r_data[w*32 +: 32] = $urandom();
        r_resp = 2'($urandom_range(3));
    endtask

    task automatic step();
        int g, dk;
        bit cap, inr, rdy;
        logic [K-1:0] kv;
        ret_t ret;
        @(posedge clk); #1;
        check("arvalid_state", m_axi_snap_arvalid, hold_m);
        check("rid_err_state", o_rid_err, err_m);
        for (int i = 0; i < K; i++) begin
            if (!pend_v[i] && req_mask[i] && $urandom_range(99) < req_pct) begin
                pend_v[i]    = 1'b1;
                pend_addr[i] = {$urandom(), $urandom()};
                pend_len[i]  = 8'($urandom_range(3));
            end
            k_arvalid[i]          = pend_v[i];
            k_araddr[i*AW +: AW]  = pend_addr[i];
            k_arlen[i*8 +: 8]     = pend_len[i];
            k_rready[i]           = ($urandom_range(99) < rr_pct);
        end
        case (ar_mode)
            1:       m_axi_snap_arready = 1'b1;
            2:       m_axi_snap_arready = 1'b0;
            default: m_axi_snap_arready = 1'($urandom_range(1));
        endcase
        if (r_en && !r_active) begin
            if ($urandom_range(99) < stray_pct) begin
                r_active = 1'b1; r_id = $urandom_range(31, K); r_left = 1; new_beat();
            end else if (ret_q.size() > 0 && $urandom_range(99) < 70) begin
                ret = ret_q.pop_front();
                r_active = 1'b1; r_id = ret.id; r_left = ret.len + 1; new_beat();
            end
        end
        m_axi_snap_rvalid = r_active;
        m_axi_snap_rid    = IDW'(r_id);
        m_axi_snap_rdata  = r_data;
        m_axi_snap_rresp  = r_resp;
        m_axi_snap_rlast  = (r_left == 1);

        // expected responses for this cycle
        cap = !hold_m || m_axi_snap_arready;
        g   = cap ? rr_pick() : -1;
        if (g >= 0) begin
            grant_q.push_back('{cyc, g});
            ar_q.push_back('{IDW'(g), pend_addr[g], pend_len[g]});
        end
        inr = (r_id < K);
        rdy = 1'b0;
        kv  = '0;
        if (r_active) begin
            rdy = inr ? k_rready[r_id] : 1'b1;
            if (inr) kv[r_id] = 1'b1;
            r_q.push_back('{kv, rdy, r_data, (r_left == 1), r_resp});
            if (!inr) err_m = 1'b1;
        end

        // advance the model to the state after the coming edge
        if (hold_m && m_axi_snap_arready) ret_q.push_back('{hold_id, hold_len});
        if (cap) begin
            if (g >= 0) begin
                hold_m = 1'b1; hold_id = g; hold_len = int'(pend_len[g]);
                last_m = g; pend_v[g] = 1'b0;
            end else begin
                hold_m = 1'b0;
            end
        end
        dk = (r_active && rdy && r_left == 1 && inr) ? r_id : -1;
        if (g >= 0 && g != dk) outs_m[g]++;
        if (dk >= 0 && dk != g && outs_m[dk] > 0) outs_m[dk]--;
        if (r_active && rdy) begin
            r_left--;
            if (r_left == 0) r_active = 1'b0;
            else new_beat();
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic model_reset();
        hold_m = 1'b0; err_m = 1'b0; last_m = K - 1;
        for (int i = 0; i < K; i++) begin
            outs_m[i] = 0; pend_v[i] = 1'b0;
        end
        ar_q.delete();
    endtask

    task automatic reset_mid_hold();
        @(posedge clk); #1;
        check("hold_pre_rst", m_axi_snap_arvalid, hold_m);
        check("rid_err_pre_rst", o_rid_err, err_m);
        k_arvalid = '0; k_rready = '0;
        m_axi_snap_arready = 1'b0; m_axi_snap_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arvalid_async_rst", m_axi_snap_arvalid, 1'b0);
        check("rid_err_async_rst", o_rid_err, 1'b0);
        check("arid_async_rst", m_axi_snap_arid, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: compares DUT outputs against scoreboard entries mid-cycle
    initial begin
        logic [K-1:0] exp_oh;
        r_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_oh = '0;
                if (grant_q.size() > 0 && grant_q[0].cyc == cyc) begin
                    exp_oh[grant_q[0].id] = 1'b1;
                    void'(grant_q.pop_front());
                end
                check("k_arready", k_arready, exp_oh);
                if (m_axi_snap_arvalid) begin
                    if (ar_q.size() == 0) begin
                        check("ar_unexpected", m_axi_snap_arvalid, 1'b0);
                    end else begin
                        check("arid", m_axi_snap_arid, ar_q[0].id);
                        check("araddr", m_axi_snap_araddr, ar_q[0].addr);
                        check("arlen", m_axi_snap_arlen, ar_q[0].len);
                        if (m_axi_snap_arready) void'(ar_q.pop_front());
                    end
                end
                if (m_axi_snap_rvalid && r_q.size() > 0) begin
                    e = r_q.pop_front();
                    check("k_rvalid", k_rvalid, e.kv);
                    check("rready", m_axi_snap_rready, e.rdy);
                    check("k_rdata", k_rdata, e.data);
                    check("k_rlast", k_rlast, e.last);
                    check("k_rresp", k_rresp, e.resp);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        k_arvalid = '0; k_araddr = '0; k_arlen = '0; k_rready = '0;
        m_axi_snap_arready = 1'b0; m_axi_snap_rvalid = 1'b0; m_axi_snap_rid = '0;
        m_axi_snap_rdata = '0; m_axi_snap_rresp = '0; m_axi_snap_rlast = 1'b0;
        r_active = 1'b0; r_id = 0; r_left = 0; r_data = '0; r_resp = '0;
        hold_id = 0; hold_len = 0;
        for (int i = 0; i < K; i++) begin
            pend_addr[i] = '0; pend_len[i] = '0;
        end
        model_reset();
        req_mask = '0; req_pct = 0; ar_mode = 1; rr_pct = 0; stray_pct = 0; r_en = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_arvalid", m_axi_snap_arvalid, 1'b0);
        check("rst_arid", m_axi_snap_arid, '0);
        check("rst_araddr", m_axi_snap_araddr, '0);
        check("rst_arlen", m_axi_snap_arlen, '0);
        check("rst_k_arready", k_arready, '0);
        check("rst_rid_err", o_rid_err, 1'b0);
        check("arsize", m_axi_snap_arsize, 3'b110);
        check("arburst", m_axi_snap_arburst, 2'b01);
        rst_n = 1'b1;

        // single request from kernel 3
        pend_v[3] = 1'b1; pend_addr[3] = 64'h1000; pend_len[3] = 8'd7;
        run(3);
        // all kernels hammering with arready high
        req_mask = '1; req_pct = 100; run(16);
        // AR backpressure
        ar_mode = 2; run(5);
        ar_mode = 1; run(2);
        // return everything
        req_mask = '0; r_en = 1'b1; rr_pct = 60; run(250);
        // kernel 0 alone hits its outstanding limit, then R data frees a slot
        req_mask = 8'h01; req_pct = 100; r_en = 1'b0; run(8);
        r_en = 1'b1; rr_pct = 100; run(30);
        // randomized mix including stray rids
        req_mask = '1; req_pct = 30; ar_mode = 0; rr_pct = 70; stray_pct = 5; run(1500);
        req_mask = '0; ar_mode = 1; rr_pct = 100; stray_pct = 0; run(300);
        // async reset while an AR is held
        req_mask = '1; req_pct = 100; ar_mode = 2; r_en = 1'b0; run(3);
        reset_mid_hold();
        ar_mode = 1; r_en = 1'b1; rr_pct = 70; stray_pct = 2; run(12);
        req_pct = 30; ar_mode = 0; run(400);
        // drain
        req_mask = '0; ar_mode = 1; rr_pct = 100; stray_pct = 0; run(400);
        @(negedge clk); #1;
        check("grant_q_left", grant_q.size(), 0);
        check("ar_q_left", ar_q.size(), 0);
        check("r_q_left", r_q.size(), 0);
        check("final_arvalid", m_axi_snap_arvalid, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
